// File: rtl/slsu.sv
// Load/store unit: RV32I funct3 decode, split of misaligned accesses into aligned
// word reads or byte writes, load extension, and bound checking against the data memory.
module slsu #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_is_store_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [4:0]            req_rd_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic [4:0]            resp_rd_o,
  output logic                  resp_err_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [1:0]            mem_size_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, LD0, LD1, ST, RESP} state_t;

  localparam logic [DATA_WIDTH-1:0] LIMIT = DATA_WIDTH'(MEM_SIZE - 3);

  state_t                  state_reg;
  logic                    is_store_reg;
  logic [2:0]              funct3_reg;
  logic [DATA_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [4:0]              rd_reg;
  logic [DATA_WIDTH-1:0]   lo_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic                    err_reg;
  logic [2:0]              nb_reg;
  logic [1:0]              cnt_reg;
  logic                    cross_reg;
  logic                    mis_reg;

  // Request decode, evaluated on the incoming fields while IDLE
  logic [2:0]            nb_in;
  logic [1:0]            off_in;
  logic                  mis_in;
  logic                  cross_in;
  logic                  legal_in;
  logic                  fault_in;
  logic [DATA_WIDTH-1:0] base_in;

  always_comb begin
    off_in = req_addr_i[1:0];
    base_in = {req_addr_i[DATA_WIDTH-1:2], 2'b00};
    case (req_funct3_i[1:0])
      2'b00:   nb_in = 3'd1;
      2'b01:   nb_in = 3'd2;
      default: nb_in = 3'd4;
    endcase
    mis_in = ((req_funct3_i[1:0] == 2'b01) && off_in[0]) ||
             ((req_funct3_i[1:0] == 2'b10) && (off_in != 2'b00));
    cross_in = ({1'b0, off_in} + nb_in) > 3'd4;
    if (req_is_store_i)
      legal_in = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) || (req_funct3_i == 3'b010);
    else
      legal_in = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) || (req_funct3_i == 3'b010) ||
                 (req_funct3_i == 3'b100) || (req_funct3_i == 3'b101);
    if (req_is_store_i)
      fault_in = mis_in ? ((req_addr_i + DATA_WIDTH'(nb_in) - DATA_WIDTH'(1)) >= LIMIT)
                        : (req_addr_i >= LIMIT);
    else
      fault_in = (base_in >= LIMIT) || (cross_in && ((base_in + DATA_WIDTH'(4)) >= LIMIT));
  end

  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] hi,
                                                   input logic [DATA_WIDTH-1:0] lo,
                                                   input logic [1:0] off,
                                                   input logic [2:0] f3);
    logic [DATA_WIDTH-1:0] sh;
    sh = DATA_WIDTH'({hi, lo} >> {off, 3'b000});
    case (f3[1:0])
      2'b00:   extend = f3[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extend = f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extend = sh;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      is_store_reg <= 1'b0;
      funct3_reg   <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rd_reg       <= '0;
      lo_reg       <= '0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
      nb_reg       <= '0;
      cnt_reg      <= '0;
      cross_reg    <= 1'b0;
      mis_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (req_valid_i) begin
          is_store_reg <= req_is_store_i;
          funct3_reg   <= req_funct3_i;
          addr_reg     <= req_addr_i;
          wdata_reg    <= req_wdata_i;
          rd_reg       <= req_rd_i;
          nb_reg       <= nb_in;
          cross_reg    <= cross_in;
          mis_reg      <= mis_in;
          cnt_reg      <= '0;
          rdata_reg    <= '0;
          if (!legal_in || fault_in) begin
            err_reg   <= 1'b1;
            state_reg <= RESP;
          end else begin
            err_reg   <= 1'b0;
            state_reg <= req_is_store_i ? ST : LD0;
          end
        end
        LD0: begin
          lo_reg <= mem_rdata_i;
          if (cross_reg) begin
            state_reg <= LD1;
          end else begin
            rdata_reg <= extend('0, mem_rdata_i, addr_reg[1:0], funct3_reg);
            state_reg <= RESP;
          end
        end
        LD1: begin
          rdata_reg <= extend(mem_rdata_i, lo_reg, addr_reg[1:0], funct3_reg);
          state_reg <= RESP;
        end
        ST: begin
          if (!mis_reg || ({1'b0, cnt_reg} == (nb_reg - 3'd1)))
            state_reg <= RESP;
          else
            cnt_reg <= cnt_reg + 2'd1;
        end
        RESP: if (resp_ready_i) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] wbyte_sh;
  assign wbyte_sh = wdata_reg >> {cnt_reg, 3'b000};

  // Memory strobes are gated by rst_n so an in-flight access dies during reset
  always_comb begin
    mem_read_o  = rst_n && ((state_reg == LD0) || (state_reg == LD1));
    mem_write_o = rst_n && (state_reg == ST) && is_store_reg;
    mem_size_o  = 2'b00;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_reg)
      LD0: begin
        mem_size_o = 2'b10;
        mem_addr_o = {addr_reg[DATA_WIDTH-1:2], 2'b00};
      end
      LD1: begin
        mem_size_o = 2'b10;
        mem_addr_o = {addr_reg[DATA_WIDTH-1:2], 2'b00} + DATA_WIDTH'(4);
      end
      ST: begin
        if (mis_reg) begin
          mem_addr_o  = addr_reg + DATA_WIDTH'(cnt_reg);
          mem_wdata_o = {24'h0, wbyte_sh[7:0]};
        end else begin
          mem_size_o  = funct3_reg[1:0];
          mem_addr_o  = addr_reg;
          mem_wdata_o = wdata_reg;
        end
      end
      default: ;
    endcase
  end

  assign req_ready_o  = (state_reg == IDLE);
  assign resp_valid_o = (state_reg == RESP);
  assign resp_rdata_o = rdata_reg;
  assign resp_rd_o    = rd_reg;
  assign resp_err_o   = err_reg;

endmodule

// File: tb/tb_slsu.sv
// Directed bench for slsu with a byte-array data memory model and hand-computed expectations.
module tb_slsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        mem_read, mem_write;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:1023];
  logic        clear;
  int          nrd, nwr;
  logic [31:0] rd_log [8];
  logic [31:0] wa_log [8];
  logic [31:0] wd_log [8];

  always #5 clk = ~clk;

  slsu #(.DATA_WIDTH(32), .MEM_SIZE(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_is_store_i(req_is_store),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rd_i(req_rd),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
    .resp_rd_o(resp_rd), .resp_err_o(resp_err),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_size_o(mem_size),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always_comb begin
    mem_rdata = '0;
    if (mem_read && mem_addr < 32'd1024)
      mem_rdata = {mem[{mem_addr[9:2], 2'b11}], mem[{mem_addr[9:2], 2'b10}],
                   mem[{mem_addr[9:2], 2'b01}], mem[{mem_addr[9:2], 2'b00}]};
  end

  always @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (mem_write && mem_addr < 32'd1024) begin
      mem[mem_addr[9:0]] <= mem_wdata[7:0];
      if (mem_size != 2'b00) mem[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
      if (mem_size == 2'b10) begin
        mem[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
        mem[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for the response (latency counted in cycles after accept), complete handshake
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd,
                        output int lat, output logic [31:0] rdata, output logic err);
    req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    nrd = 0; nwr = 0; lat = 0; rdata = 'x; err = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      if (mem_read && nrd < 8) begin rd_log[nrd] = mem_addr; nrd++; end
      if (mem_write && nwr < 8) begin wa_log[nwr] = mem_addr; wd_log[nwr] = mem_wdata; nwr++; end
      if (resp_valid) begin lat = c; rdata = resp_rdata; err = resp_err; break; end
      @(posedge clk); #1;
    end
    check("resp_timeout", 32'(lat != 0), 32'd1);
    check("resp_rd", 32'(resp_rd), 32'(rd));
    $display("txn st=%0d f3=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d reads=%0d writes=%0d",
             st, f3, addr, wd, rdata, err, lat, nrd, nwr);
    @(posedge clk); #1;
  endtask

  int          lat;
  logic [31:0] rdata;
  logic        err;
  int          hits;

  initial begin
    rst_n = 1'b0; clear = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1; clear = 1'b0;

    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);

    // 1: sign/zero extension
    do_req(1'b1, 3'b010, 32'h10, 32'h80FF7F02, 5'd0, lat, rdata, err);
    check("sw10_lat", 32'(lat), 32'd2);
    check("sw10_wr", wd_log[0], 32'h80FF7F02);
    do_req(1'b0, 3'b000, 32'h13, 32'h0, 5'd3, lat, rdata, err);
    check("lb13_data", rdata, 32'hFFFFFF80);
    check("lb13_lat", 32'(lat), 32'd2);
    check("lb13_err", 32'(err), 32'd0);
    do_req(1'b0, 3'b100, 32'h13, 32'h0, 5'd4, lat, rdata, err);
    check("lbu13_data", rdata, 32'h00000080);
    check("lbu13_lat", 32'(lat), 32'd2);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, 5'd5, lat, rdata, err);
    check("lh12_data", rdata, 32'hFFFF80FF);
    check("lh12_lat", 32'(lat), 32'd2);
    check("lh12_err", 32'(err), 32'd0);

    // 2: crossing word load
    do_req(1'b1, 3'b010, 32'h0C, 32'h44332211, 5'd0, lat, rdata, err);
    do_req(1'b1, 3'b010, 32'h10, 32'h88776655, 5'd0, lat, rdata, err);
    do_req(1'b0, 3'b010, 32'h0E, 32'h0, 5'd6, lat, rdata, err);
    check("lw0e_data", rdata, 32'h66554433);
    check("lw0e_lat", 32'(lat), 32'd3);
    check("lw0e_nreads", 32'(nrd), 32'd2);
    check("lw0e_rd0", rd_log[0], 32'h0C);
    check("lw0e_rd1", rd_log[1], 32'h10);

    // 3: misaligned store split into bytes
    do_req(1'b1, 3'b010, 32'h20, 32'h0, 5'd0, lat, rdata, err);
    do_req(1'b1, 3'b010, 32'h21, 32'hDDCCBBAA, 5'd0, lat, rdata, err);
    check("sw21_lat", 32'(lat), 32'd5);
    check("sw21_nwr", 32'(nwr), 32'd4);
    check("sw21_a0", wa_log[0], 32'h21);
    check("sw21_d0", wd_log[0], 32'h000000AA);
    check("sw21_a3", wa_log[3], 32'h24);
    check("sw21_d3", wd_log[3], 32'h000000DD);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 5'd8, lat, rdata, err);
    check("lw20_data", rdata, 32'hCCBBAA00);

    // 4: error paths and bounds
    do_req(1'b1, 3'b000, 32'h3FD, 32'h5A, 5'd0, lat, rdata, err);
    check("sb3fd_err", 32'(err), 32'd1);
    check("sb3fd_lat", 32'(lat), 32'd1);
    check("sb3fd_nacc", 32'(nrd + nwr), 32'd0);
    do_req(1'b0, 3'b010, 32'h3FE, 32'h0, 5'd9, lat, rdata, err);
    check("lw3fe_err", 32'(err), 32'd1);
    check("lw3fe_data", rdata, 32'h0);
    check("lw3fe_nacc", 32'(nrd + nwr), 32'd0);
    do_req(1'b0, 3'b011, 32'h40, 32'h0, 5'd10, lat, rdata, err);
    check("ld011_err", 32'(err), 32'd1);
    check("ld011_lat", 32'(lat), 32'd1);
    check("ld011_nacc", 32'(nrd + nwr), 32'd0);
    do_req(1'b1, 3'b100, 32'h40, 32'h1, 5'd0, lat, rdata, err);
    check("st100_err", 32'(err), 32'd1);
    check("st100_nacc", 32'(nrd + nwr), 32'd0);
    do_req(1'b0, 3'b010, 32'h3FC, 32'h0, 5'd11, lat, rdata, err);
    check("lw3fc_err", 32'(err), 32'd0);
    check("lw3fc_lat", 32'(lat), 32'd2);

    // 5: response back-pressure
    resp_ready = 1'b0;
    req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_rd = 5'd7;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (resp_valid) begin lat = c; break; end
      @(posedge clk); #1;
    end
    check("bp_lat", 32'(lat), 32'd2);
    req_addr = 32'h0C; req_rd = 5'd9; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_rdata", resp_rdata, 32'h88776655);
      check("bp_rd", 32'(resp_rd), 32'd7);
      check("bp_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    check("bp_valid_last", 32'(resp_valid), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_done_valid", 32'(resp_valid), 32'd0);
    check("bp_done_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_not_taken", 32'(req_ready), 32'd1);
    $display("txn backpressure lw addr=00000010 lat=%0d", lat);

    // 6: reset in the middle of a misaligned store
    req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h31; req_wdata = 32'h11223344;
    req_rd = 5'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rs_w0", {mem_write, mem_addr[30:0]}, 32'h80000031);
    check("rs_d0", mem_wdata, 32'h44);
    @(posedge clk); #1;
    check("rs_w1", {mem_write, mem_addr[30:0]}, 32'h80000032);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rs_gate_write", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    check("rs_in_write", 32'(mem_write), 32'd0);
    check("rs_in_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rs_ready", 32'(req_ready), 32'd1);
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid || mem_write) hits++;
      @(posedge clk); #1;
    end
    check("rs_quiet", 32'(hits), 32'd0);
    check("rs_mem32", 32'(mem[10'h032]), 32'h33);
    check("rs_mem33", 32'(mem[10'h033]), 32'h00);
    check("rs_mem34", 32'(mem[10'h034]), 32'h00);
    $display("txn reset_mid_store addr=00000031 writes_before_reset=2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slsu.md
Name: slsu

Overview:
- Load/store unit between the execute stage and the byte-addressable data memory `sdatamem`.
- Accepts one load/store request at a time over a valid/ready handshake, decodes RV32I funct3, and drives the memory's read/write/size/address/data controls.
- Aligned accesses go to memory as one access. Misaligned accesses are split: two aligned word reads for loads, successive byte writes for stores.
- Loads are returned with sign or zero extension, and accesses outside memory bounds are flagged.

Parameters:
- DATA_WIDTH, 32, data and address width (only 32 supported).
- MEM_SIZE, 1024, memory size in bytes. Must match the data memory, be a multiple of 4, and be at least 8.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- req_valid_i  input  1  request valid
- req_ready_o  output  1  unit can accept a request
- req_is_store_i  input  1  1=store, 0=load
- req_funct3_i  input  3  RV32I load/store funct3
- req_addr_i  input  32  byte address
- req_wdata_i  input  32  store data
- req_rd_i  input  5  load destination register
- resp_valid_o  output  1  response valid
- resp_ready_i  input  1  consumer accepts response
- resp_rdata_o  output  32  extended load data (0 for stores and errors)
- resp_rd_o  output  5  latched rd
- resp_err_o  output  1  illegal funct3 or out-of-bounds access
- mem_read_o  output  1  to data memory read enable
- mem_write_o  output  1  to data memory write enable
- mem_size_o  output  2  00 byte, 01 half, 10 word
- mem_addr_o  output  32  memory address
- mem_wdata_o  output  32  memory write data
- mem_rdata_i  input  32  combinational read data from memory

Behaviour:
- **Reset** (sync, at posedge with rst_n=0): state IDLE; all registered outputs 0; req_ready_o=1 after the reset edge.
  - mem_write_o and mem_read_o are also combinationally ANDed with rst_n.
  - Reset mid-operation aborts: no further memory accesses and no response.
- **States:** IDLE, LD0, LD1, ST, RESP.
- **IDLE:** req_ready_o=1. On req_valid_i at a clock edge, latch all req_* fields and compute:
  - nbytes: 1/2/4 from funct3[1:0].
  - off = addr[1:0].
  - misaligned = addr not naturally aligned.
  - cross = off+nbytes>4.
- **Legal funct3:**
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
- **Error path:** an illegal funct3 or a fault goes IDLE→RESP with err=1 and rdata=0, and issues no memory access.
- **Fault:** any address this unit would drive is ≥ MEM_SIZE-3.
  - Loads: aligned base addr&~3, plus base+4 if cross.
  - Stores: addr if aligned, else addr+nbytes-1.
- **Load:** IDLE→LD0.
  - LD0: mem_read_o=1, size=10, addr=addr&~3; capture mem_rdata_i into lo at the edge. Go to LD1 if cross, else RESP.
  - LD1: mem_read_o=1, size=10, addr=(addr&~3)+4; capture hi; go to RESP.
  - Result = ({hi,lo} >> 8*off) truncated to nbytes.
  - Sign-extend for funct3[2]=0, zero-extend for funct3[2]=1.
- **Store:** IDLE→ST.
  - If not misaligned: one cycle with mem_write_o=1, size=funct3[1:0], addr=addr, wdata=req_wdata.
  - If misaligned: nbytes cycles with a 2-bit counter k, each with size=00, addr=addr+k, wdata[7:0]=byte k of the data, other bits 0.
  - After the last write, go to RESP.
- **RESP:** resp_valid_o=1 with rdata/rd/err held stable until resp_ready_i=1, then IDLE.
  - req_ready_o=0 in every state except IDLE.
  - No request is accepted in the same cycle a response completes.
- **Outputs outside active states:** mem_read_o/mem_write_o are 0 outside LD0/LD1/ST, and mem_addr_o/mem_wdata_o/mem_size_o are 0 outside active states.
- **Latency** (accept at edge N, resp_ready_i=1):
  - Aligned or non-crossing load: resp_valid at N+2.
  - Crossing load: resp_valid at N+3.
  - Aligned store: resp_valid at N+2.
  - Misaligned store: resp_valid at N+1+nbytes.
  - Error: resp_valid at N+1.
- **Address arithmetic:** 32-bit, wraps modulo 2^32; wrapped addresses fault by the bound rule.

Test Plan:
1. SW 0x10 = 0x80FF7F02, then LB 0x13, LBU 0x13, LH 0x12 → rdata 0xFFFFFF80, 0x00000080, 0xFFFF80FF. Each load has resp_valid 2 cycles after accept and err=0.
2. SW 0x0C = 0x44332211, SW 0x10 = 0x88776655, then LW 0x0E → mem reads at 0x0C then 0x10, rdata 0x66554433, resp_valid at N+3.
3. SW 0x20 = 0, then SW 0x21 data 0xDDCCBBAA → byte writes 0xAA, 0xBB, 0xCC, 0xDD to 0x21–0x24 on cycles N+1..N+4, resp at N+5. A following LW 0x20 returns 0xCCBBAA00.
4. SB 0x3FD, LW 0x3FE, and load funct3=011 (MEM_SIZE=1024) → err=1, rdata=0, resp at N+1, no mem_read_o/mem_write_o pulse. LW 0x3FC → err=0.
5. Hold resp_ready_i=0 for 3 cycles after LW → resp_valid, rdata and rd stable, req_ready_o=0, a new req_valid is ignored until the handshake completes.
6. Assert rst_n=0 after 2 of the 4 byte writes of a misaligned SW → no further mem_write_o, no resp_valid, req_ready_o=1 the cycle after rst_n returns high.
